// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES round sequencer.
//   seq_state_e : operation state (IDLE / RUN / DONE)
//   KEYLEN_*    : key_len encodings used to pick the round count
//   DEF_*       : default widths and round counts for the sequencer
package aes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;

  localparam int DEF_INNER_W    = 4;
  localparam int DEF_INNER_MAX  = 15;
  localparam int DEF_ROUND_W    = 4;
  localparam int DEF_ROUNDS_128 = 10;
  localparam int DEF_ROUNDS_192 = 12;
  localparam int DEF_ROUNDS_256 = 14;

endpackage

// File: rtl/aes_mod_counter.sv
// Generic W-bit modulo counter: counts 0..terminal_i and wraps to 0.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : advance by one (or wrap) this cycle
//   clr_i       : synchronous clear, wins over en_i
//   terminal_i  : last value before wrapping
//   count_o     : current count
//   wrap_o      : en_i && count_o == terminal_i (the count wraps on this edge)
module aes_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] terminal_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;
  logic         at_term;

  assign at_term = (count_q == terminal_i);
  assign wrap_o  = en_i && at_term;
  assign count_o = count_q;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      // Terminal compare fires before the field could overflow.
      count_d = at_term ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment for registered state avoids simulation ordering races.
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_datapath_round_sequencer.sv
// AES round sequencer: an inner-step counter nested inside a round counter
// whose length (10/12/14 rounds) is latched from key_len when an operation
// starts. Provides start/busy/done handshake, stall hold and last-step flags.
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   rst_synch           : synchronous clear, beats start and stall
//   start               : begin an operation (accepted in IDLE or DONE)
//   key_len             : round-count select, sampled when start is accepted
//   stall               : freeze counters while running
//   inner_state_counter : current inner step
//   round_counter       : current 0-based round
//   inner_last          : busy and inner step at INNER_MAX
//   round_last          : busy and in the final round
//   busy                : operation running
//   done                : one-cycle completion pulse
// All outputs decode from registers; there is no input-to-output path.
module aes_datapath_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int INNER_W    = DEF_INNER_W,
  parameter int INNER_MAX  = DEF_INNER_MAX,
  parameter int ROUND_W    = DEF_ROUND_W,
  parameter int ROUNDS_128 = DEF_ROUNDS_128,
  parameter int ROUNDS_192 = DEF_ROUNDS_192,
  parameter int ROUNDS_256 = DEF_ROUNDS_256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_synch,
  input  logic               start,
  input  logic [1:0]         key_len,
  input  logic               stall,
  output logic [INNER_W-1:0] inner_state_counter,
  output logic [ROUND_W-1:0] round_counter,
  output logic               inner_last,
  output logic               round_last,
  output logic               busy,
  output logic               done
);

  // One extra bit so a full 2**ROUND_W round count is representable.
  localparam int RT_W = ROUND_W + 1;

  if (INNER_MAX < 1 || INNER_MAX > (1 << INNER_W) - 1) begin : g_bad_inner_max
    $error("INNER_MAX must lie in 1..2**INNER_W-1");
  end
  if (ROUNDS_128 < 1 || ROUNDS_128 > (1 << ROUND_W) ||
      ROUNDS_192 < 1 || ROUNDS_192 > (1 << ROUND_W) ||
      ROUNDS_256 < 1 || ROUNDS_256 > (1 << ROUND_W)) begin : g_bad_rounds
    $error("every ROUNDS_* must lie in 1..2**ROUND_W");
  end

  seq_state_e        state_q, state_d;
  logic [RT_W-1:0]   rounds_total_q, rounds_total_d;
  logic [RT_W-1:0]   rounds_sel;
  logic [ROUND_W-1:0] round_term;
  logic              inner_en;
  logic              inner_wrap;
  logic              round_wrap;

  always_comb begin
    case (key_len)
      KEYLEN_192: rounds_sel = RT_W'(ROUNDS_192);
      KEYLEN_256: rounds_sel = RT_W'(ROUNDS_256);
      default:    rounds_sel = RT_W'(ROUNDS_128);  // 128 and reserved 2'b11
    endcase
  end

  // rounds_total is never 0, so the final round index always fits ROUND_W bits.
  assign round_term = ROUND_W'(rounds_total_q - 1'b1);
  assign inner_en   = (state_q == RUN) && !stall;

  // Both counters return to 0 on the final step, so they read 0 in DONE and IDLE.
  aes_mod_counter #(.W(INNER_W)) u_inner (
    .clk        (clk),
    .rst_n      (rst),
    .en_i       (inner_en),
    .clr_i      (rst_synch),
    .terminal_i (INNER_W'(INNER_MAX)),
    .count_o    (inner_state_counter),
    .wrap_o     (inner_wrap)
  );

  aes_mod_counter #(.W(ROUND_W)) u_round (
    .clk        (clk),
    .rst_n      (rst),
    .en_i       (inner_wrap),
    .clr_i      (rst_synch),
    .terminal_i (round_term),
    .count_o    (round_counter),
    .wrap_o     (round_wrap)
  );

  always_comb begin
    state_d        = state_q;
    rounds_total_d = rounds_total_q;
    if (rst_synch) begin
      state_d        = IDLE;
      rounds_total_d = RT_W'(ROUNDS_128);
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts start directly for back-to-back operations.
          if (start) begin
            state_d        = RUN;
            rounds_total_d = rounds_sel;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          // round_wrap only fires on an unstalled final step.
          if (round_wrap) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      rounds_total_q <= RT_W'(ROUNDS_128);
    end else begin
      state_q        <= state_d;
      rounds_total_q <= rounds_total_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign inner_last = busy && (inner_state_counter == INNER_W'(INNER_MAX));
  assign round_last = busy && (round_counter == round_term);

endmodule

// File: tb/tb_aes_datapath_round_sequencer.sv
module tb_aes_datapath_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_synch;
  logic       start;
  logic [1:0] key_len;
  logic       stall;
  logic [3:0] inner_state_counter;
  logic [3:0] round_counter;
  logic       inner_last;
  logic       round_last;
  logic       busy;
  logic       done;

  aes_datapath_round_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .rst_synch           (rst_synch),
    .start               (start),
    .key_len             (key_len),
    .stall               (stall),
    .inner_state_counter (inner_state_counter),
    .round_counter       (round_counter),
    .inner_last          (inner_last),
    .round_last          (round_last),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       inner_last;
    logic       round_last;
    logic [3:0] inner;
    logic [3:0] rnd;
  } obs_t;

  obs_t exp_q[$];   // expected outputs after each edge
  int   len_q[$];   // expected busy length of each completed operation
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: an operation is a count of completed steps out of
  // rounds*16; the counters are just the quotient and remainder of that count.
  bit m_active;
  bit m_done;
  int m_step;
  int m_rounds;
  int m_stalls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rounds_of(input logic [1:0] k);
    case (k)
      2'b01:   return 12;
      2'b10:   return 14;
      default: return 10;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.busy       = m_active;
    o.done       = m_done;
    o.inner      = m_active ? 4'(m_step % 16) : 4'd0;
    o.rnd        = m_active ? 4'(m_step / 16) : 4'd0;
    o.inner_last = m_active && (m_step % 16 == 15);
    o.round_last = m_active && (m_step / 16 == m_rounds - 1);
    return o;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_step   = 0;
    m_rounds = 10;
    m_stalls = 0;
  endtask

  // Drive one cycle of inputs mid-cycle and predict the state after the next edge.
  task automatic cycle(input bit st, input logic [1:0] kl, input bit sl, input bit rs);
    @(posedge clk);
    #4;
    rst       = 1'b1;
    start     = st;
    key_len   = kl;
    stall     = sl;
    rst_synch = rs;
    if (rs) begin
      model_reset();
    end else if (m_active) begin
      m_done = 1'b0;
      if (sl) begin
        m_stalls++;
      end else begin
        m_step++;
        if (m_step == m_rounds * 16) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_step   = 0;
          len_q.push_back(m_rounds * 16 + m_stalls);
        end
      end
    end else begin
      m_done = 1'b0;
      if (st) begin
        m_active = 1'b1;
        m_rounds = rounds_of(kl);
        m_step   = 0;
        m_stalls = 0;
      end
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic drain(input bit noise, input int stall_pct, input int rs_per_mille);
    for (int i = 0; i < 3000 && m_active; i++) begin
      bit rs;
      rs = int'($urandom % 1000) < rs_per_mille;
      cycle(noise ? 1'($urandom) : 1'b0, 2'($urandom),
            int'($urandom % 100) < stall_pct, rs);
    end
  endtask

  task automatic run_to(input int step);
    for (int i = 0; i < 3000 && m_active && m_step != step; i++)
      cycle(1'b0, 2'($urandom), 1'b0, 1'b0);
  endtask

  task automatic async_reset_now();
    @(posedge clk);
    #4;
    rst       = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    rst_synch = 1'b0;
    #1;
    check("async_rst_immediate",
          32'({busy, done, inner_last, round_last, inner_state_counter, round_counter}), 32'd0);
    model_reset();
    exp_q.push_back(model_obs());
  endtask

  // Monitor: compares every cycle against the queued prediction and checks
  // the busy length of each operation when its done pulse appears.
  initial begin : monitor
    obs_t e;
    obs_t a;
    int   run;
    run = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {busy, done, inner_last, round_last, inner_state_counter, round_counter};
        cyc++;
        check($sformatf("obs@%0d", cyc), 32'(a), 32'(e));
        if (a.done) begin
          check("done_has_op", 32'(len_q.size() > 0), 32'd1);
          if (len_q.size() > 0) check("busy_len", run, len_q.pop_front());
          run = 0;
        end else if (a.busy) begin
          run++;
        end else begin
          run = 0;
        end
      end
    end
  end

  initial begin : driver
    rst       = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    rst_synch = 1'b0;
    key_len   = 2'b00;
    model_reset();
    #12;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_inner", 32'(inner_state_counter), 32'd0);
    check("rst_round", 32'(round_counter), 32'd0);
    check("rst_flags", 32'({inner_last, round_last}), 32'd0);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // AES-128, no stall
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    drain(1'b0, 0, 0);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // AES-256 then reserved encoding
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    drain(1'b0, 0, 0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    drain(1'b0, 0, 0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Stall 5 cycles at round 2, inner 7
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    run_to(2 * 16 + 7);
    repeat (5) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    drain(1'b0, 0, 0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Synchronous clear with start at round 4, inner 3 (AES-192)
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    run_to(4 * 16 + 3);
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Back-to-back: AES-192 started in the DONE cycle of AES-128, start noise during run
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    drain(1'b0, 0, 0);
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    drain(1'b1, 0, 0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset at round 6
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    run_to(6 * 16 + 5);
    async_reset_now();
    repeat (4) cycle(1'b0, 2'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    drain(1'b0, 0, 0);

    // Randomized operations: stalls, start/key_len noise, rare sync clears, random gaps
    repeat (14) begin
      cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
      drain(1'b1, 12, 3);
      if ($urandom % 3 == 0)
        repeat (int'($urandom % 4)) cycle(1'b0, 2'($urandom), 1'($urandom), 1'b0);
    end
    repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    check("exp_q_drained", exp_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
